// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 one-hot decoder: codes arrive over valid/ready into a FIFO, each is
// held on a registered one-hot output for dwell+1 enabled cycles. Define DECODER_GAP_EN for break-before-make.
module decoder_3to8_seq #(
  parameter int DWELL_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2:0]         in_code,
  output logic               in_ready,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               en,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic               busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [DWELL_W-1:0] hold_cnt, hold_next;
  logic [2:0]         code, code_next;
  logic [7:0]         out_next;

  logic [2:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               full, empty, push, pop;
  logic [2:0]         head;

  // Handshake depends only on registered occupancy, never on a same-cycle pop.
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || !empty;

  // NOTE: storage array has no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      code      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      code      <= code_next;
      out       <= out_next;
      out_valid <= |out_next;
    end
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (en && hold_cnt == '0) begin
`ifdef DECODER_GAP_EN
          state_next = GAP;
`else
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
`endif
        end
      end
`ifdef DECODER_GAP_EN
      GAP: begin
        if (en && !empty) begin
          pop        = 1'b1;
          state_next = HOLD;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output is blank unless a code is being loaded or an enabled hold continues.
  always_comb begin
    out_next  = '0;
    hold_next = hold_cnt;
    code_next = code;
    if (pop) begin
      code_next = head;
      hold_next = dwell;
      out_next  = 8'(1) << head;
    end else if (state == HOLD && en && hold_cnt != '0) begin
      hold_next = hold_cnt - 1'b1;
      out_next  = 8'(1) << code;
    end
  end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Self-checking bench for decoder_3to8_seq: table vectors, directed corner sequences and
// random traffic compared each cycle against a queue-based reference model.
module tb_decoder_3to8_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [3:0] dwell;
  logic       en;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model: pending codes, current code (-1 when none), enabled edges left, gap flag.
  int q[$];
  int cur;
  int left;
  bit gap;
  logic [7:0] exp_out;

  typedef struct {
    logic [2:0] code;
    logic [3:0] dw;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] rec[$];

  decoder_3to8_seq #(.DWELL_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .dwell(dwell), .en(en), .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur = -1;
    left = 0;
    gap = 0;
  endtask

  task automatic model_pop();
    cur  = q.pop_front();
    left = int'(dwell);
  endtask

  task automatic model_step();
    bit rdy = (q.size() < DEPTH);
    int pushed = (in_valid && rdy) ? int'(in_code) : -1;
    if (gap) begin
      gap = 0;
      if (en && q.size() > 0) model_pop();
    end else if (en) begin
      if (cur < 0) begin
        if (q.size() > 0) model_pop();
      end else if (left > 0) begin
        left--;
      end else begin
`ifdef DECODER_GAP_EN
        cur = -1;
        gap = 1;
`else
        if (q.size() > 0) model_pop();
        else cur = -1;
`endif
      end
    end
    if (pushed >= 0) q.push_back(pushed);
    exp_out = (en && cur >= 0) ? 8'(1 << cur) : 8'h00;
  endtask

  // One clock: advance the model on the same input values, then compare just after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("out", 32'(out), 32'(exp_out));
    check("out_valid", 32'(out_valid), 32'(exp_out != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("busy", 32'(busy), 32'(cur >= 0 || gap || q.size() > 0));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int s;
    int n6;
    int n1;
    bit acc;

    vecs[0] = '{3'd5, 4'd0, 8'b0010_0000};
    vecs[1] = '{3'd0, 4'd1, 8'b0000_0001};
    vecs[2] = '{3'd7, 4'd2, 8'b1000_0000};
    vecs[3] = '{3'd3, 4'd0, 8'b0000_1000};
    vecs[4] = '{3'd1, 4'd3, 8'b0000_0010};
    vecs[5] = '{3'd6, 4'd1, 8'b0100_0000};
    vecs[6] = '{3'd2, 4'd2, 8'b0000_0100};
    vecs[7] = '{3'd4, 4'd0, 8'b0001_0000};

    rst = 1'b1; in_valid = 1'b0; in_code = '0; dwell = '0; en = 1'b1;
    model_reset();
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Table vectors: each code alone, visible exactly dw+1 cycles, then blank.
    for (int v = 0; v < 8; v++) begin
      dwell = vecs[v].dw; in_code = vecs[v].code; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= int'(vecs[v].dw); k++) begin
        tick();
        check("vec_hold", 32'(out), 32'(vecs[v].exp));
      end
      tick();
      check("vec_end", 32'(out), 32'h0);
      idle(2);
      check("vec_idle_busy", 32'(busy), 32'h0);
    end

    // Sweep 0..7 back-to-back with dwell=2.
    dwell = 4'd2;
    rec.delete();
    for (int i = 0; i < 8; ) begin
      in_valid = 1'b1; in_code = 3'(i); acc = in_ready;
      tick();
      rec.push_back(out);
      if (acc) i++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); rec.push_back(out); end
    s = 0;
    while (s < rec.size() && rec[s] == 8'h00) s++;
`ifdef DECODER_GAP_EN
    for (int j = 0; j < 32; j++)
      check("sweep", 32'(rec[s+j]), (j % 4 < 3) ? 32'(1 << (j / 4)) : 32'h0);
    for (int j = 32; j < 40; j++) check("sweep_tail", 32'(rec[s+j]), 32'h0);
`else
    for (int j = 0; j < 24; j++) check("sweep", 32'(rec[s+j]), 32'(1 << (j / 3)));
    for (int j = 24; j < 32; j++) check("sweep_tail", 32'(rec[s+j]), 32'h0);
`endif

    // Full FIFO with decoding paused.
    en = 1'b0; dwell = 4'd0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = 3'(i + 2);
      tick();
      check("full_out", 32'(out), 32'h0);
      if (i == 3) check("full_ready", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    en = 1'b1;
    idle(12);
    check("full_drained", 32'(busy), 32'h0);

    // Enable pause mid-hold.
    dwell = 4'd3; in_code = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); check("pause_vis1", 32'(out), 32'h04);
    tick(); check("pause_vis2", 32'(out), 32'h04);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); check("pause_blank", 32'(out), 32'h0); end
    en = 1'b1;
    tick(); check("pause_resume1", 32'(out), 32'h04);
    tick(); check("pause_resume2", 32'(out), 32'h04);
    tick(); check("pause_end", 32'(out), 32'h0);
    idle(3);

    // Dwell sampled only at pop.
    dwell = 4'd1; in_code = 3'd6; in_valid = 1'b1;
    tick();
    in_code = 3'd1;
    tick();
    in_valid = 1'b0;
    dwell = 4'd7;
    n6 = (out == 8'h40) ? 1 : 0;
    n1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out == 8'h40) n6++;
      if (out == 8'h02) n1++;
    end
    check("dwell_first", 32'(n6), 32'd2);
    check("dwell_second", 32'(n1), 32'd8);

    // Asynchronous reset mid-hold with codes queued.
    dwell = 4'd5;
    for (int i = 1; i <= 4; i++) begin in_valid = 1'b1; in_code = 3'(i); tick(); end
    in_valid = 1'b0;
    tick();
    check("pre_rst_out", 32'(out), 32'h02);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_ready", 32'(in_ready), 32'h1);
    check("async_rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); check("post_rst_out", 32'(out), 32'h0); end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_code  = 3'($urandom_range(0, 7));
      dwell    = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      en       = ($urandom_range(0, 7) != 0);
      tick();
    end
    en = 1'b1;
    idle(80);
    check("final_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
